// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the run controller: state encoding and default sizes.
package cpu_ctrl_pkg;

  localparam int DIV_WIDTH_DEF  = 21;
  localparam int DEB_CYCLES_DEF = 16;
  localparam int CYC_WIDTH_DEF  = 16;

  // Sequencer states; binary encoded, outputs are decoded into registers.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_PAUSE = 3'd2;
  localparam logic [2:0] ST_STEP  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF synchronizer, counting debouncer and a
// one-cycle pulse on the rising edge of the accepted level.
module btn_conditioner #(
  parameter int DEB_CYCLES = 16
) (
  input  logic fpgaclock,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;

  // Bring the asynchronous button into the fpgaclock domain.
  always_ff @(posedge fpgaclock) begin
    if (reset) r_sync <= 2'b00;
    else       r_sync <= {r_sync[0], i_btn};
  end

  // Accept a new level only after DEB_CYCLES consecutive differing samples;
  // any sample equal to the current level restarts the count.
  always_ff @(posedge fpgaclock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= r_level;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // A held button produces a single pulse: only the 0->1 transition counts.
  assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/cpu_run_controller.sv
// Run/step/interrupt sequencer for the basic-computer core. Produces a
// single-cycle clock enable from a free-running divider and walks the core
// through idle, run, pause, single-step and halt.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH  = DIV_WIDTH_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CYC_WIDTH  = CYC_WIDTH_DEF
) (
  input  logic                 fpgaclock,
  input  logic                 reset,
  input  logic                 start_btn,
  input  logic                 step_btn,
  input  logic                 intr_btn,
  input  logic                 halted,
  output logic                 core_ce,
  output logic                 core_rst,
  output logic                 ready,
  output logic                 busy,
  output logic                 interrupted,
  output logic                 halt_seen,
  output logic [CYC_WIDTH-1:0] cycle_count
);

  logic                 w_start_p, w_step_p, w_intr_p;
  logic                 w_tick;
  logic [2:0]           w_next;
  logic                 w_ce_next;
  logic                 w_clr;

  logic [DIV_WIDTH-1:0] r_div;
  logic [2:0]           r_state;
  logic                 r_ce;
  logic                 r_core_rst, r_ready, r_busy, r_intr, r_halt;
  logic [CYC_WIDTH-1:0] r_cnt;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_start (
    .fpgaclock(fpgaclock), .reset(reset), .i_btn(start_btn), .o_press(w_start_p));
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_step (
    .fpgaclock(fpgaclock), .reset(reset), .i_btn(step_btn), .o_press(w_step_p));
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_intr (
    .fpgaclock(fpgaclock), .reset(reset), .i_btn(intr_btn), .o_press(w_intr_p));

  // Free-running divider; tick marks the all-ones count.
  always_ff @(posedge fpgaclock) begin
    if (reset) r_div <= '0;
    else       r_div <= r_div + DIV_WIDTH'(1);
  end

  assign w_tick = &r_div;

  // Next-state and enable decision. STEP stays put for the cycle in which
  // its single core_ce is out, then drops back to PAUSE.
  always_comb begin
    w_next    = r_state;
    w_ce_next = 1'b0;
    w_clr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_p) begin
          w_next = ST_RUN;
          w_clr  = 1'b1;
        end else if (w_step_p) begin
          w_next = ST_STEP;
          w_clr  = 1'b1;
        end
      end
      ST_RUN: begin
        if (halted)                w_next    = ST_HALT;
        else if (w_intr_p)         w_next    = ST_PAUSE;
        else if (w_tick && !r_ce)  w_ce_next = 1'b1;
      end
      ST_PAUSE: begin
        if (halted)         w_next = ST_HALT;
        else if (w_intr_p)  w_next = ST_RUN;
        else if (w_step_p)  w_next = ST_STEP;
      end
      ST_STEP: begin
        if (r_ce)         w_next    = ST_PAUSE;
        else if (w_tick)  w_ce_next = 1'b1;
      end
      ST_HALT: begin
        if (w_start_p) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, enable and status flags, all registered from the next state.
  always_ff @(posedge fpgaclock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ce       <= 1'b0;
      r_core_rst <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_intr     <= 1'b0;
      r_halt     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ce       <= w_ce_next;
      r_core_rst <= (w_next == ST_IDLE);
      r_ready    <= (w_next == ST_IDLE);
      r_busy     <= (w_next == ST_RUN) || (w_next == ST_STEP);
      r_intr     <= (w_next == ST_PAUSE);
      r_halt     <= (w_next == ST_HALT);
    end
  end

  // Count issued enables since the last start; saturate instead of wrapping.
  always_ff @(posedge fpgaclock) begin
    if (reset)                r_cnt <= '0;
    else if (w_clr)           r_cnt <= '0;
    else if (r_ce && !(&r_cnt)) r_cnt <= r_cnt + CYC_WIDTH'(1);
  end

  assign core_ce     = r_ce;
  assign core_rst    = r_core_rst;
  assign ready       = r_ready;
  assign busy        = r_busy;
  assign interrupted = r_intr;
  assign halt_seen   = r_halt;
  assign cycle_count = r_cnt;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller with a 16-cycle tick and 4-sample
// debounce. A second instance with a 3-bit cycle counter shares all inputs.
module tb_cpu_run_controller;

  logic fpgaclock = 1'b0;
  logic reset     = 1'b1;
  logic start_btn = 1'b0;
  logic step_btn  = 1'b0;
  logic intr_btn  = 1'b0;
  logic halted    = 1'b0;

  logic        core_ce, core_rst, ready, busy, interrupted, halt_seen;
  logic [15:0] cycle_count;
  logic        core_ce2, core_rst2, ready2, busy2, interrupted2, halt_seen2;
  logic [2:0]  cycle_count2;

  int vectors     = 0;
  int miscompares = 0;
  int ce_cnt      = 0;
  int ce2_cnt     = 0;
  logic prev_ce   = 1'b0;

  always #5 fpgaclock = ~fpgaclock;

  cpu_run_controller #(.DIV_WIDTH(4), .DEB_CYCLES(4), .CYC_WIDTH(16)) dut (
    .fpgaclock(fpgaclock), .reset(reset), .start_btn(start_btn),
    .step_btn(step_btn), .intr_btn(intr_btn), .halted(halted),
    .core_ce(core_ce), .core_rst(core_rst), .ready(ready), .busy(busy),
    .interrupted(interrupted), .halt_seen(halt_seen), .cycle_count(cycle_count));

  cpu_run_controller #(.DIV_WIDTH(4), .DEB_CYCLES(4), .CYC_WIDTH(3)) dut2 (
    .fpgaclock(fpgaclock), .reset(reset), .start_btn(start_btn),
    .step_btn(step_btn), .intr_btn(intr_btn), .halted(halted),
    .core_ce(core_ce2), .core_rst(core_rst2), .ready(ready2), .busy(busy2),
    .interrupted(interrupted2), .halt_seen(halt_seen2), .cycle_count(cycle_count2));

  // Advance n cycles, sampling 1ns after each edge; tally enables and flag
  // any enable that follows another immediately.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge fpgaclock); #1;
      if (core_ce2) ce2_cnt++;
      if (core_ce) begin
        ce_cnt++;
        vectors++;
        if (prev_ce) begin
          miscompares++;
          $display("FAIL ce_back_to_back got two consecutive core_ce want isolated pulses");
        end
      end
      prev_ce = core_ce;
    end
  endtask

  // Run until core_ce is seen (bounded); n returns cycles waited.
  task automatic wait_ce(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      cyc(1);
      n++;
      if (core_ce) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_ce_timeout got no core_ce in 64 cycles want a pulse");
    end
  endtask

  // Hold one button for hold cycles, release, then let it settle.
  task automatic press(input int which, input int hold, input int settle);
    case (which)
      0: start_btn = 1'b1;
      1: step_btn  = 1'b1;
      default: intr_btn = 1'b1;
    endcase
    cyc(hold);
    start_btn = 1'b0; step_btn = 1'b0; intr_btn = 1'b0;
    cyc(settle);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(3);
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %0b want 1", ready); end
    vectors++; if (core_rst !== 1'b1) begin miscompares++; $display("FAIL reset_core_rst got %0b want 1", core_rst); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
    vectors++; if (interrupted !== 1'b0) begin miscompares++; $display("FAIL reset_intr got %0b want 0", interrupted); end
    vectors++; if (halt_seen !== 1'b0) begin miscompares++; $display("FAIL reset_halt got %0b want 0", halt_seen); end
    vectors++; if (core_ce !== 1'b0) begin miscompares++; $display("FAIL reset_ce got %0b want 0", core_ce); end
    vectors++; if (cycle_count !== 16'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", cycle_count); end
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_glitch();
    start_btn = 1'b1;
    cyc(3);
    start_btn = 1'b0;
    cyc(12);
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL glitch_ready got %0b want 1", ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy got %0b want 0", busy); end
  endtask

  task automatic test_run();
    int base, n;
    base = ce_cnt;
    // Accepted after 2 sync + 4 debounce edges, state moves on the 7th.
    start_btn = 1'b1;
    cyc(10);
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL run_ready got %0b want 0", ready); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL run_busy got %0b want 1", busy); end
    vectors++; if (core_rst !== 1'b0) begin miscompares++; $display("FAIL run_core_rst got %0b want 0", core_rst); end
    start_btn = 1'b0;
    wait_ce(n);
    for (int k = 0; k < 6 && (ce_cnt - base) < 5; k++) begin
      wait_ce(n);
      vectors++; if (n != 16) begin miscompares++; $display("FAIL run_ce_spacing got %0d want 16", n); end
    end
    cyc(1);
    vectors++; if (cycle_count !== 16'd5) begin miscompares++; $display("FAIL run_count got %0d want 5", cycle_count); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL run_still_busy got %0b want 1", busy); end
  endtask

  task automatic test_pause_step();
    int c, b, n;
    press(2, 8, 8);
    vectors++; if (interrupted !== 1'b1) begin miscompares++; $display("FAIL pause_intr got %0b want 1", interrupted); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL pause_busy got %0b want 0", busy); end
    c = int'(cycle_count);
    b = ce_cnt;
    cyc(40);
    vectors++; if (ce_cnt != b) begin miscompares++; $display("FAIL pause_no_ce got %0d pulses want 0", ce_cnt - b); end
    vectors++; if (cycle_count !== 16'(c)) begin miscompares++; $display("FAIL pause_count got %0d want %0d", cycle_count, c); end
    b = ce_cnt;
    press(1, 8, 40);
    vectors++; if (ce_cnt - b != 1) begin miscompares++; $display("FAIL step_ce got %0d pulses want 1", ce_cnt - b); end
    vectors++; if (cycle_count !== 16'(c + 1)) begin miscompares++; $display("FAIL step_count got %0d want %0d", cycle_count, c + 1); end
    vectors++; if (interrupted !== 1'b1) begin miscompares++; $display("FAIL step_back_pause got %0b want 1", interrupted); end
    press(2, 8, 8);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL resume_busy got %0b want 1", busy); end
    vectors++; if (interrupted !== 1'b0) begin miscompares++; $display("FAIL resume_intr got %0b want 0", interrupted); end
    wait_ce(n);
  endtask

  task automatic test_halt();
    int b;
    // In a core_ce cycle the divider reads 0; 15 cycles on is the tick.
    cyc(15);
    vectors++; if (dut.w_tick !== 1'b1) begin miscompares++; $display("FAIL halt_align_tick got %0b want 1", dut.w_tick); end
    halted = 1'b1;
    cyc(1);
    vectors++; if (halt_seen !== 1'b1) begin miscompares++; $display("FAIL halt_seen got %0b want 1", halt_seen); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL halt_busy got %0b want 0", busy); end
    vectors++; if (core_ce !== 1'b0) begin miscompares++; $display("FAIL halt_ce got %0b want 0", core_ce); end
    halted = 1'b0;
    b = ce_cnt;
    press(1, 8, 24);
    vectors++; if (ce_cnt != b) begin miscompares++; $display("FAIL halt_no_ce got %0d pulses want 0", ce_cnt - b); end
    vectors++; if (halt_seen !== 1'b1) begin miscompares++; $display("FAIL halt_step_ignored got %0b want 1", halt_seen); end
    press(0, 8, 8);
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL halt_to_idle got %0b want 1", ready); end
    vectors++; if (core_rst !== 1'b1) begin miscompares++; $display("FAIL halt_core_rst got %0b want 1", core_rst); end
    vectors++; if (halt_seen !== 1'b0) begin miscompares++; $display("FAIL halt_cleared got %0b want 0", halt_seen); end
  endtask

  task automatic test_saturate();
    int base, base2, n;
    base  = ce_cnt;
    base2 = ce2_cnt;
    press(0, 10, 0);
    for (int k = 0; k < 12 && (ce_cnt - base) < 9; k++) wait_ce(n);
    cyc(1);
    vectors++; if (cycle_count !== 16'd9) begin miscompares++; $display("FAIL sat_wide_count got %0d want 9", cycle_count); end
    vectors++; if (cycle_count2 !== 3'd7) begin miscompares++; $display("FAIL sat_narrow_count got %0d want 7", cycle_count2); end
    vectors++; if (ce2_cnt - base2 != 9) begin miscompares++; $display("FAIL sat_narrow_ce got %0d pulses want 9", ce2_cnt - base2); end
  endtask

  task automatic test_reset_step();
    int b;
    bit hit;
    press(2, 8, 8);
    vectors++; if (interrupted !== 1'b1) begin miscompares++; $display("FAIL rst_pause got %0b want 1", interrupted); end
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (dut.r_div == 4'd0) hit = 1'b1; else cyc(1);
    end
    // Step accepted at divider 7, so STEP is waiting when the divider hits 14.
    b = ce_cnt;
    press(1, 8, 0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (dut.r_div == 4'd14) hit = 1'b1; else cyc(1);
    end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_in_step got %0b want 1", busy); end
    reset = 1'b1;
    cyc(1);
    vectors++; if (core_ce !== 1'b0) begin miscompares++; $display("FAIL rst_ce got %0b want 0", core_ce); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %0b want 1", ready); end
    vectors++; if (core_rst !== 1'b1) begin miscompares++; $display("FAIL rst_core_rst got %0b want 1", core_rst); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %0b want 0", busy); end
    vectors++; if (cycle_count !== 16'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", cycle_count); end
    vectors++; if (dut.r_div !== 4'd0) begin miscompares++; $display("FAIL rst_div got %0d want 0", dut.r_div); end
    reset = 1'b0;
    cyc(3);
    vectors++; if (ce_cnt != b) begin miscompares++; $display("FAIL rst_no_ce got %0d pulses want 0", ce_cnt - b); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rst_stays_idle got %0b want 1", ready); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_run();
    test_pause_step();
    test_halt();
    test_saturate();
    test_reset_step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Run/step/interrupt sequencer for the basic-computer core. Replaces the gated slow clock with a single-cycle clock-enable (core_ce) derived from a free-running divider on fpgaclock, so the core runs entirely on fpgaclock. Conditions the three board push-buttons. Sequences the core through idle, free-run, paused, single-step and halted modes, and reports status to the board LEDs.

Parameters:
DIV_WIDTH, 21, divider width; one tick every 2^DIV_WIDTH fpgaclock cycles.
DEB_CYCLES, 16, consecutive stable samples required before a button level is accepted.
CYC_WIDTH, 16, width of the executed-cycle counter.

Ports:
fpgaclock  in  1  system clock
reset  in  1  synchronous, active-high; clock fpgaclock
start_btn  in  1  raw start button, asynchronous
step_btn  in  1  raw single-step button, asynchronous
intr_btn  in  1  raw interrupt/resume button, asynchronous
halted  in  1  core halt flag, synchronous to fpgaclock
core_ce  out  1  one-fpgaclock-cycle enable; the core advances one cycle per pulse
core_rst  out  1  core synchronous reset
ready  out  1  state IDLE
busy  out  1  state RUN or STEP
interrupted  out  1  state PAUSE
halt_seen  out  1  state HALT
cycle_count  out  CYC_WIDTH  core_ce pulses since last run start, saturating

Behaviour:
- Button conditioning:
  - 2-FF synchronizer, then debounce: the accepted level changes only after DEB_CYCLES consecutive equal samples.
  - Rising edge of the accepted level gives a one-cycle press pulse (start_p, step_p, intr_p).
  - Holding a button gives exactly one pulse.
- Divider: counter wraps from all-ones to 0. tick=1 in the cycle the counter equals all-ones.
- core_ce is registered and is never high for two consecutive cycles.
- States, one-hot-decodable outputs, all registered:
  - IDLE: ready=1, core_rst=1.
  - RUN: busy=1.
  - PAUSE: interrupted=1.
  - STEP: busy=1.
  - HALT: halt_seen=1.
- Reset values: state IDLE; ready=1, core_rst=1; busy, interrupted, halt_seen, core_ce=0; cycle_count=0; divider=0; debouncers at accepted level 0.
- IDLE:
  - start_p: RUN; cycle_count cleared.
  - step_p: STEP; cycle_count cleared.
  - intr_p: ignored.
  - core_rst deasserts in the cycle the state leaves IDLE.
- RUN, priority halted > intr_p > tick:
  - halted=1: HALT, no core_ce.
  - intr_p: PAUSE, no core_ce in that cycle even if tick=1.
  - tick: core_ce=1 next cycle.
  - step_p, start_p: ignored.
- PAUSE, priority halted > intr_p > step_p:
  - halted=1: HALT.
  - intr_p: RUN.
  - step_p: STEP.
  - start_p: ignored.
- STEP:
  - Waits for the next tick, issues exactly one core_ce, then returns to PAUSE in the following cycle.
  - Presses during STEP are ignored.
- HALT:
  - start_p: IDLE (core held in reset until the next start).
  - Other presses are ignored.
- cycle_count increments in the cycle core_ce=1. Holds at 2^CYC_WIDTH-1 (no wrap).
- Reset mid-operation (any state, including a pending core_ce): next cycle is the reset state. core_ce=0 and the divider restarts at 0.
- Latency from a press to core_ce: debounce (2 + DEB_CYCLES cycles) + state change (1) + wait for tick (0 to 2^DIV_WIDTH-1 cycles) + 1.

Decomposition:
- Package cpu_ctrl_pkg: state enumeration (IDLE, RUN, PAUSE, STEP, HALT) and its encoding; default DIV_WIDTH, DEB_CYCLES and CYC_WIDTH constants.
- Sub-module btn_conditioner (synchronizer + debounce + rising-edge pulse, parameter DEB_CYCLES), instantiated three times.
- Divider and FSM stay in the top.

Test Plan:
(Bench uses DIV_WIDTH=4, DEB_CYCLES=4; tick every 16 cycles.)
1. Reset, then start_btn held 10 cycles -> ready falls, busy=1. core_ce pulses are 16 cycles apart. After 5 ticks cycle_count=5. One start pulse only.
2. Start_btn glitch of 3 cycles -> no state change, ready stays 1.
3. RUN, intr press -> interrupted=1, no further core_ce. Step press -> exactly one core_ce, cycle_count +1, returns to PAUSE. Intr press -> RUN resumes.
4. RUN, halted=1 coinciding with tick -> HALT, halt_seen=1, no core_ce in that cycle. Start press -> IDLE, core_rst=1.
5. RUN with cycle_count forced near max via CYC_WIDTH=3 -> counter stops at 7 while core_ce continues.
6. reset asserted during STEP one cycle before the tick -> no core_ce. Next cycle: ready=1, core_rst=1, cycle_count=0, divider=0.
